core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
Core memory module acting as the responder end of the processor memory bus. It accepts read, write and read-modify-write cycles from the processor and returns an address acknowledge and read restart. It sequences a timed read/restore core cycle over a 36-bit word array. It sits beside the processor as a bus target and is instanced per memory module, selected by its address range.

Parameters:
ADDR_W, 14, word address bits inside the module (default 16K words, 'o40000).
MODULE_SEL, 0, value the high (18-ADDR_W) bits of membus_ma must match.
READ_DLY, 4, clocks from address acknowledge to data available (min 1).
WRITE_DLY, 4, clocks of restore/write phase (min 1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
membus_rq_cyc  in  1  processor requests a memory cycle
membus_rd_rq  in  1  read requested
membus_wr_rq  in  1  write requested (with rd_rq set: read-modify-write)
membus_ma  in  18  word address
membus_mb_out  in  36  write data from processor
membus_wr_rs  in  1  processor write restart: membus_mb_out valid
membus_addr_ack  out  1  one-clock pulse: address accepted
membus_rd_rs  out  1  one-clock pulse: read data valid
membus_mb_in  out  36  read data to processor
mem_busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ACK, READ, RDRS, WAITWR, WRITE.
- Reset (any time, async): state IDLE; all outputs 0; delay counter 0; armed flag set. Core array is NOT cleared. Cycle aborted mid-flight leaves the addressed word unchanged.
- IDLE: accepts when rq_cyc & (rd_rq | wr_rq) & armed & ma high bits == MODULE_SEL. Latches ma low ADDR_W bits, rd and wr flags. Clears armed and goes to ACK.
- IDLE ignores: rq_cyc with neither rd_rq nor wr_rq, and address mismatch.
- ACK: membus_addr_ack = 1 for exactly this clock. Go to READ, counter = READ_DLY-1.
- READ: counter decrements. At 0: buffer = core[ma] if rd flag, else buffer = 0.
  - If rd flag, go to RDRS; else go to WAITWR.
- RDRS: membus_rd_rs = 1 for one clock. membus_mb_in = buffer from this clock until return to IDLE, 0 otherwise.
  - Next state: WAITWR if wr flag, else WRITE (restore).
- WAITWR: holds until membus_wr_rs = 1, then buffer = membus_mb_out and go to WRITE. membus_wr_rs is ignored in every other state.
- WRITE: counter = WRITE_DLY-1, decrements. At 0: core[ma] = buffer, go to IDLE.
- Latencies:
  - rq_cyc sampled to addr_ack: 1 clock.
  - addr_ack to rd_rs: READ_DLY+1 clocks.
  - Read-only cycle total: 3+READ_DLY+WRITE_DLY clocks.
- armed is set again only when rq_cyc is sampled low. A held rq_cyc never starts a second cycle.
- rq_cyc, rd_rq or wr_rq dropping mid-cycle: the cycle completes per the latched flags. The core is always restored.
- New requests while mem_busy = 1 are not queued. The processor re-presents them.
- Address wrap: none. Only the low ADDR_W bits index the array.

Optional Feature:
CORE_SINGLE_STEP_EN:
- When defined, adds inputs sw_single_step and sw_restart (1 bit each) and state STEPHOLD.
- With sw_single_step = 1, WRITE completion goes to STEPHOLD instead of IDLE. mem_busy stays high and requests are ignored.
- A rising edge of sw_restart (edge-detected internally) moves STEPHOLD to IDLE.
- Reset clears STEPHOLD.
- When undefined: ports and state are absent, and WRITE always returns to IDLE.

Test Plan:
- Preload core['o20] = 'o200064000104. Read at ma 'o20 with MODULE_SEL 0 -> addr_ack 1 clock later, rd_rs READ_DLY+1 later, mb_in = 'o200064000104, and core['o20] unchanged after the cycle.
- Write 'o777000001000 to 'o1000: wr_rq, then wr_rs 3 clocks after addr_ack -> no rd_rs, core['o1000] = 'o777000001000 after WRITE_DLY clocks. Delayed wr_rs (20 clocks) holds WAITWR with mem_busy = 1.
- Read-modify-write at 'o10410 (preload 'o333) -> rd_rs with mb_in = 'o333; wr_rs with mb_out = 'o334 -> core['o10410] = 'o334.
- MODULE_SEL = 1, ma = 'o20 -> no addr_ack, mem_busy stays 0. ma = 'o40020 -> accepted, and the word stored at index 'o20.
- rq_cyc held high across two cycles -> only one addr_ack. Reset pulse during READ -> outputs 0 immediately, state IDLE, addressed word unchanged.
- With CORE_SINGLE_STEP_EN and sw_single_step = 1: after a cycle, mem_busy stays 1 and a second request gets no ack. A sw_restart pulse -> next request acked.

Source files
------------

// File: rtl/core_mem_responder.sv
// Core memory responder on the processor memory bus: timed read/restore cycle over a 36-bit word array.
// Optional feature macro CORE_SINGLE_STEP_EN adds sw_single_step/sw_restart and a STEPHOLD state.
module core_mem_responder #(
   parameter int unsigned ADDR_W     = 14,
   parameter int unsigned MODULE_SEL = 0,
   parameter int unsigned READ_DLY   = 4,
   parameter int unsigned WRITE_DLY  = 4
) (
   input  logic        clk,
   input  logic        reset,
`ifdef CORE_SINGLE_STEP_EN
   input  logic        sw_single_step,
   input  logic        sw_restart,
`endif
   input  logic        membus_rq_cyc,
   input  logic        membus_rd_rq,
   input  logic        membus_wr_rq,
   input  logic [17:0] membus_ma,
   input  logic [35:0] membus_mb_out,
   input  logic        membus_wr_rs,
   output logic        membus_addr_ack,
   output logic        membus_rd_rs,
   output logic [35:0] membus_mb_in,
   output logic        mem_busy
);

   localparam int unsigned SEL_W   = 18 - ADDR_W;
   localparam int unsigned MAX_DLY = (READ_DLY > WRITE_DLY) ? READ_DLY : WRITE_DLY;
   localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);
   localparam int unsigned DEPTH   = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACK    = 3'd1,
      S_READ   = 3'd2,
      S_RDRS   = 3'd3,
      S_WAITWR = 3'd4,
`ifdef CORE_SINGLE_STEP_EN
      S_STEPHOLD = 3'd6,
`endif
      S_WRITE  = 3'd5
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_armed, w_armed_nxt;
   logic [ADDR_W-1:0]  r_ma, w_ma_nxt;
   logic               r_rd, w_rd_nxt;
   logic               r_wr, w_wr_nxt;
   logic [35:0]        r_buf, w_buf_nxt;
   logic               r_ack, r_rs, r_busy;
   logic [35:0]        r_mb_in, w_mb_in_nxt;
   logic               w_core_we;
   logic               w_accept;
   logic               w_step_hold;
   logic               w_restart_rise;
   logic [35:0]        w_core_rd;
   logic [35:0]        r_core [DEPTH];

`ifdef CORE_SINGLE_STEP_EN
   logic r_restart_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_restart_q <= 1'b0;
      else        r_restart_q <= sw_restart;
   end
   assign w_restart_rise = sw_restart & ~r_restart_q;
   assign w_step_hold    = sw_single_step;
`else
   assign w_restart_rise = 1'b0;
   assign w_step_hold    = 1'b0;
`endif

   assign w_core_rd = r_core[r_ma];
   assign w_accept  = membus_rq_cyc & (membus_rd_rq | membus_wr_rq) & r_armed &
                      (membus_ma[17:ADDR_W] == SEL_W'(MODULE_SEL));

   // Next-state, counter and buffer sequencing of the core cycle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_armed_nxt = r_armed | ~membus_rq_cyc;
      w_ma_nxt    = r_ma;
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_buf_nxt   = r_buf;
      w_core_we   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_ACK;
               w_ma_nxt    = membus_ma[ADDR_W-1:0];
               w_rd_nxt    = membus_rd_rq;
               w_wr_nxt    = membus_wr_rq;
               w_armed_nxt = 1'b0;
            end
         end
         S_ACK: begin
            w_state_nxt = S_READ;
            w_cnt_nxt   = CNT_W'(READ_DLY - 1);
         end
         S_READ: begin
            if (r_cnt == '0) begin
               w_buf_nxt   = r_rd ? w_core_rd : 36'd0;
               w_state_nxt = r_rd ? S_RDRS : S_WAITWR;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_RDRS: begin
            if (r_wr) begin
               w_state_nxt = S_WAITWR;
            end else begin
               w_state_nxt = S_WRITE;
               w_cnt_nxt   = CNT_W'(WRITE_DLY - 1);
            end
         end
         S_WAITWR: begin
            if (membus_wr_rs) begin
               w_buf_nxt   = membus_mb_out;
               w_state_nxt = S_WRITE;
               w_cnt_nxt   = CNT_W'(WRITE_DLY - 1);
            end
         end
         S_WRITE: begin
            if (r_cnt == '0) begin
               w_core_we   = 1'b1;
`ifdef CORE_SINGLE_STEP_EN
               w_state_nxt = w_step_hold ? S_STEPHOLD : S_IDLE;
`else
               w_state_nxt = S_IDLE;
`endif
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
`ifdef CORE_SINGLE_STEP_EN
         S_STEPHOLD: begin
            if (w_restart_rise) w_state_nxt = S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read data is presented from the read-restart clock until the cycle ends
   always_comb begin
      w_mb_in_nxt = 36'd0;
      if (w_rd_nxt && (w_state_nxt != S_IDLE) && (w_state_nxt != S_ACK) && (w_state_nxt != S_READ))
         w_mb_in_nxt = w_buf_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_armed <= 1'b1;
         r_ma    <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_buf   <= 36'd0;
         r_ack   <= 1'b0;
         r_rs    <= 1'b0;
         r_busy  <= 1'b0;
         r_mb_in <= 36'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_armed <= w_armed_nxt;
         r_ma    <= w_ma_nxt;
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_buf   <= w_buf_nxt;
         r_ack   <= (w_state_nxt == S_ACK);
         r_rs    <= (w_state_nxt == S_RDRS);
         r_busy  <= (w_state_nxt != S_IDLE);
         r_mb_in <= w_mb_in_nxt;
      end
   end

   // Core array has no reset; only a completed WRITE phase updates it
   always_ff @(posedge clk) begin
      if (w_core_we) r_core[r_ma] <= r_buf;
   end

   assign membus_addr_ack = r_ack;
   assign membus_rd_rs    = r_rs;
   assign membus_mb_in    = r_mb_in;
   assign mem_busy        = r_busy;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: two instances (MODULE_SEL 0 and 1) share one bus; read data
// is checked through a scoreboard queue, cycle timing by a vector table plus hand sequences.
module tb_core_mem_responder;

   localparam int unsigned RD = 4;
   localparam int unsigned WD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rq_cyc, rd_rq, wr_rq, wr_rs;
   logic [17:0] ma;
   logic [35:0] mb_out;
   logic [1:0]  ack_w, rs_w, busy_w;
   logic [35:0] mbin_w [2];
`ifdef CORE_SINGLE_STEP_EN
   logic        sw_ss, sw_restart;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          d;
      logic [35:0] data;
   } sb_t;
   sb_t sb_q [$];

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [17:0] ma;
      logic [35:0] wd;
      int          wrs_dly;
   } vec_t;

   logic [35:0] model [logic [17:0]];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      core_mem_responder #(.ADDR_W(14), .MODULE_SEL(g), .READ_DLY(RD), .WRITE_DLY(WD)) dut (
         .clk             (clk),
         .reset           (reset),
`ifdef CORE_SINGLE_STEP_EN
         .sw_single_step  (sw_ss),
         .sw_restart      (sw_restart),
`endif
         .membus_rq_cyc   (rq_cyc),
         .membus_rd_rq    (rd_rq),
         .membus_wr_rq    (wr_rq),
         .membus_ma       (ma),
         .membus_mb_out   (mb_out),
         .membus_wr_rs    (wr_rs),
         .membus_addr_ack (ack_w[g]),
         .membus_rd_rs    (rs_w[g]),
         .membus_mb_in    (mbin_w[g]),
         .mem_busy        (busy_w[g])
      );
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0o expected %0o at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int d, input logic [17:0] a);
      sb_t e;
      e.d    = d;
      e.data = model.exists(a) ? model[a] : 36'd0;
      sb_q.push_back(e);
   endtask

   // Scoreboard: every read restart must match the oldest expected read
   always @(negedge clk) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            if (rs_w[d]) begin
               if (sb_q.size() == 0) begin
                  check("sb_underflow", 64'(d + 1), 64'd0);
               end else begin
                  sb_t e;
                  e = sb_q.pop_front();
                  check("sb_dut", 64'(d), 64'(e.d));
                  check("sb_data", 64'(mbin_w[d]), 64'(e.data));
               end
            end
         end
      end
   end

   task automatic run_cycle(input vec_t v);
      int   match;
      int   n_ack [2];
      int   n_rs  [2];
      bit   seen_busy [2];
      int   ack_at, rs_at, done_at;
      bit   fin;
      logic [3:0] hi;
      hi      = v.ma[17:14];
      match   = (hi < 4'd2) ? int'(hi) : -1;
      ack_at  = 0; rs_at = 0; done_at = 0; fin = 1'b0;
      for (int d = 0; d < 2; d++) begin n_ack[d] = 0; n_rs[d] = 0; seen_busy[d] = 1'b0; end
      if (v.rd && match >= 0) push_exp(match, v.ma);
      rq_cyc = 1'b1; rd_rq = v.rd; wr_rq = v.wr; ma = v.ma; mb_out = v.wd;
      for (int t = 1; t <= 100; t++) begin
         step();
         if (t == 1) begin rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; end
         for (int d = 0; d < 2; d++) begin
            if (ack_w[d]) begin n_ack[d]++; if (d == match) ack_at = t; end
            if (rs_w[d])  begin n_rs[d]++;  if (d == match) rs_at = t; end
            if (busy_w[d]) seen_busy[d] = 1'b1;
         end
         if (match >= 0 && v.wr && ack_at > 0 && t == ack_at + v.wrs_dly) begin
            check({v.name, "_waitwr_busy"}, 64'(busy_w[match]), 64'd1);
            wr_rs = 1'b1;
         end
         if (t >= 2 && busy_w == 2'b00) begin done_at = t; fin = 1'b1; break; end
      end
      wr_rs = 1'b0;
      if (!fin) check({v.name, "_timeout"}, 64'd1, 64'd0);
      for (int d = 0; d < 2; d++) begin
         check({v.name, "_ack_cnt"}, 64'(n_ack[d]), 64'(d == match));
         check({v.name, "_rs_cnt"}, 64'(n_rs[d]), 64'((d == match) && v.rd));
         check({v.name, "_busy_seen"}, 64'(seen_busy[d]), 64'(d == match));
      end
      if (match >= 0) begin
         check({v.name, "_ack_lat"}, 64'(ack_at), 64'd1);
         if (v.rd) check({v.name, "_rs_lat"}, 64'(rs_at - ack_at), 64'(RD + 1));
         if (v.rd && !v.wr) check({v.name, "_cyc_len"}, 64'(done_at), 64'(3 + RD + WD));
         if (v.wr) model[v.ma] = v.wd;
      end
      step();
   endtask

   vec_t vecs [11];

   initial begin
      int n;
      vecs[0]  = '{"wr20",     1'b0, 1'b1, 18'o000020, 36'o200064000104, 3};
      vecs[1]  = '{"rd20",     1'b1, 1'b0, 18'o000020, 36'o0,            0};
      vecs[2]  = '{"rd20b",    1'b1, 1'b0, 18'o000020, 36'o0,            0};
      vecs[3]  = '{"wr1000",   1'b0, 1'b1, 18'o001000, 36'o777000001000, 3};
      vecs[4]  = '{"rd1000",   1'b1, 1'b0, 18'o001000, 36'o0,            0};
      vecs[5]  = '{"wr10410",  1'b0, 1'b1, 18'o010410, 36'o333,          20};
      vecs[6]  = '{"rmw10410", 1'b1, 1'b1, 18'o010410, 36'o334,          3};
      vecs[7]  = '{"rd10410",  1'b1, 1'b0, 18'o010410, 36'o0,            0};
      vecs[8]  = '{"wr40020",  1'b0, 1'b1, 18'o040020, 36'o123456701234, 3};
      vecs[9]  = '{"rd40020",  1'b1, 1'b0, 18'o040020, 36'o0,            0};
      vecs[10] = '{"nosel",    1'b1, 1'b0, 18'o200020, 36'o0,            0};

      reset = 1'b0; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; wr_rs = 1'b0;
      ma = '0; mb_out = '0;
`ifdef CORE_SINGLE_STEP_EN
      sw_ss = 1'b0; sw_restart = 1'b0;
`endif
      step(); step();
      check("rst_ack", 64'(ack_w), 64'd0);
      check("rst_busy", 64'(busy_w), 64'd0);
      check("rst_mbin", 64'(mbin_w[0]), 64'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 11; i++) run_cycle(vecs[i]);

      // Request held high across the whole cycle gets acknowledged once
      push_exp(0, 18'o000020);
      rq_cyc = 1'b1; rd_rq = 1'b1; ma = 18'o000020; n = 0;
      for (int t = 0; t < 30; t++) begin step(); if (ack_w[0]) n++; end
      check("held_ack_cnt", 64'(n), 64'd1);
      check("held_busy", 64'(busy_w[0]), 64'd0);
      rq_cyc = 1'b0; rd_rq = 1'b0;
      step(); step();

      // Reset in the READ phase aborts the write and clears outputs at once
      rq_cyc = 1'b1; wr_rq = 1'b1; ma = 18'o001000; mb_out = 36'o123;
      step();
      check("abort_ack", 64'(ack_w[0]), 64'd1);
      rq_cyc = 1'b0; wr_rq = 1'b0; wr_rs = 1'b1;
      step(); step();
      reset = 1'b0;
      #1;
      check("abort_ack0", 64'(ack_w[0]), 64'd0);
      check("abort_busy0", 64'(busy_w[0]), 64'd0);
      check("abort_rs0", 64'(rs_w[0]), 64'd0);
      wr_rs = 1'b0;
      step();
      reset = 1'b1;
      step();
      run_cycle('{"rd1000_after_abort", 1'b1, 1'b0, 18'o001000, 36'o0, 0});

`ifdef CORE_SINGLE_STEP_EN
      sw_ss = 1'b1;
      push_exp(0, 18'o000020);
      rq_cyc = 1'b1; rd_rq = 1'b1; ma = 18'o000020;
      step();
      rq_cyc = 1'b0; rd_rq = 1'b0;
      for (int t = 0; t < 14; t++) step();
      check("ss_hold_busy", 64'(busy_w[0]), 64'd1);
      rq_cyc = 1'b1; rd_rq = 1'b1; n = 0;
      for (int t = 0; t < 6; t++) begin step(); if (ack_w[0]) n++; end
      check("ss_no_ack", 64'(n), 64'd0);
      rq_cyc = 1'b0; rd_rq = 1'b0;
      sw_restart = 1'b1;
      step();
      sw_restart = 1'b0;
      step();
      check("ss_release", 64'(busy_w[0]), 64'd0);
      sw_ss = 1'b0;
      run_cycle('{"ss_rd20", 1'b1, 1'b0, 18'o000020, 36'o0, 0});
`endif

      step(); step();
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
